// File: rtl/noc_pkg.sv
// Shared constants and types for the NoC router output allocators.
// Port indices follow the router's L, N, E, W, S ordering.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam logic [2:0] P_L = 3'd0;
    localparam logic [2:0] P_N = 3'd1;
    localparam logic [2:0] P_E = 3'd2;
    localparam logic [2:0] P_W = 3'd3;
    localparam logic [2:0] P_S = 3'd4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    function automatic logic [NUM_PORTS-1:0] onehot5(input logic [2:0] idx);
        logic [NUM_PORTS-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Combinational round-robin picker over five requesters.
// Searches upward from ptr, wrapping 4 -> 0; ptr must be 0..4.
module rr_arbiter5
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [2:0]           ptr,
    output logic [2:0]           winner,
    output logic                 any
);

    always_comb begin
        logic [3:0] idx;
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        // Walk from the farthest offset down so the nearest requester wins.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NUM_PORTS)) begin
                idx = idx - 4'(NUM_PORTS);
            end
            if (req[idx[2:0]]) begin
                winner = idx[2:0];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_output_allocator.sv
// Per-output allocator: packet-locked round-robin arbitration plus
// credit-based flow control toward the downstream input buffer.
module noc_output_allocator
    import noc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic [NUM_PORTS-1:0] req_tail,
    input  logic                 credit_in,
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] xbar_sel,
    output logic                 flit_send,
    output logic [CW-1:0]        credit_cnt,
    output logic                 busy,
    output logic                 credit_err
);

    alloc_state_t state_q, state_d;
    logic [2:0]    owner_q, owner_d;
    logic [2:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          err_q, err_d;

    logic [2:0]    arb_winner;
    logic          arb_any;
    logic          owner_go;

    rr_arbiter5 u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .winner (arb_winner),
        .any    (arb_any)
    );

    assign owner_go = (state_q == LOCKED) && req_valid[owner_q] && (credit_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= P_L;
            rr_ptr_q <= P_L;
            credit_q <= CW'(DEPTH);
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    owner_d = arb_winner;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (owner_go && req_tail[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == P_S) ? P_L : owner_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant    = '0;
        xbar_sel = '0;
        busy     = 1'b0;
        if (state_q == LOCKED) begin
            busy     = 1'b1;
            xbar_sel = onehot5(owner_q);
            if (owner_go) begin
                grant = onehot5(owner_q);
            end
        end
    end

    assign flit_send = |grant;

    // A return while full is a downstream protocol error: hold at DEPTH and flag it.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        unique case ({flit_send, credit_in})
            2'b10: credit_d = credit_q - CW'(1);
            2'b01: begin
                if (credit_q == CW'(DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d = credit_q + CW'(1);
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    assign credit_cnt = credit_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_noc_output_allocator.sv
// Directed bench for noc_output_allocator: arbitration order, packet lock,
// credit stall/return/overflow and reset mid-packet, with DEPTH=4.
module tb_noc_output_allocator;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    req_valid;
    logic [4:0]    req_tail;
    logic          credit_in;
    logic [4:0]    grant;
    logic [4:0]    xbar_sel;
    logic          flit_send;
    logic [CW-1:0] credit_cnt;
    logic          busy;
    logic          credit_err;

    int vectors     = 0;
    int miscompares = 0;

    noc_output_allocator #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_tail   (req_tail),
        .credit_in  (credit_in),
        .grant      (grant),
        .xbar_sel   (xbar_sel),
        .flit_send  (flit_send),
        .credit_cnt (credit_cnt),
        .busy       (busy),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [4:0] g, input logic [4:0] x,
                             input logic b, input logic [CW-1:0] c);
        chk({tag, ".grant"},     32'(grant),      32'(g));
        chk({tag, ".xbar_sel"},  32'(xbar_sel),   32'(x));
        chk({tag, ".flit_send"}, 32'(flit_send),  32'(|g));
        chk({tag, ".busy"},      32'(busy),       32'(b));
        chk({tag, ".credit"},    32'(credit_cnt), 32'(c));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] rr_order [6];
        rr_order = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

        rst = 1'b1; req_valid = '0; req_tail = '0; credit_in = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk_state("reset", 5'b0, 5'b0, 1'b0, 3'd4);
        chk("reset.err", 32'(credit_err), 32'd0);

        // Single-flit packet from E, then credit refill and overflow.
        req_valid = 5'b00100; req_tail = 5'b00100;
        #1; chk_state("a_idle", 5'b0, 5'b0, 1'b0, 3'd4);
        cyc(); chk_state("a_send", 5'b00100, 5'b00100, 1'b1, 3'd4);
        cyc(); req_valid = '0; req_tail = '0; credit_in = 1'b1;
        #1; chk_state("a_done", 5'b0, 5'b0, 1'b0, 3'd3);
        cyc(); chk("a_refill.cnt", 32'(credit_cnt), 32'd4);
        chk("a_refill.err", 32'(credit_err), 32'd0);
        cyc(); credit_in = 1'b0;
        #1; chk("a_ovf.cnt", 32'(credit_cnt), 32'd4);
        chk("a_ovf.err", 32'(credit_err), 32'd1);
        cyc(); req_valid = 5'b11111; req_tail = 5'b11111;
        #1; chk("a_sticky.err", 32'(credit_err), 32'd1);
        chk("a_sticky.grant", 32'(grant), 32'd0);
        // rr_ptr was left at 3 by E's tail, so W wins among all five.
        cyc(); chk_state("a_rr", 5'b01000, 5'b01000, 1'b1, 3'd4);

        // Fairness: every port sends single flits; credits returned on each send.
        rst = 1'b1; cyc(); rst = 1'b0;
        #1; chk("b_rst.err", 32'(credit_err), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk_state($sformatf("b_idle%0d", i), 5'b0, 5'b0, 1'b0, 3'd4);
            cyc(); credit_in = 1'b1;
            #1; chk_state($sformatf("b_send%0d", i), rr_order[i], rr_order[i], 1'b1, 3'd4);
            cyc(); credit_in = 1'b0;
            #1;
        end

        // Packet lock: E holds the output across a stall while N waits.
        req_valid = '0; req_tail = '0;
        rst = 1'b1; cyc(); rst = 1'b0;
        req_valid = 5'b00100;
        #1; cyc(); req_valid = 5'b00110;
        #1; chk_state("c_f1", 5'b00100, 5'b00100, 1'b1, 3'd4);
        cyc(); req_valid = 5'b00010;
        #1; chk_state("c_wait", 5'b0, 5'b00100, 1'b1, 3'd3);
        cyc(); req_valid = 5'b00110;
        #1; chk_state("c_f2", 5'b00100, 5'b00100, 1'b1, 3'd3);
        cyc(); req_tail = 5'b00100; credit_in = 1'b1;
        #1; chk_state("c_f3", 5'b00100, 5'b00100, 1'b1, 3'd2);
        cyc(); credit_in = 1'b0; req_valid = 5'b00010; req_tail = 5'b00010;
        #1; chk_state("c_arb", 5'b0, 5'b0, 1'b0, 3'd2);
        cyc(); credit_in = 1'b1;
        #1; chk_state("c_n", 5'b00010, 5'b00010, 1'b1, 3'd2);
        cyc(); credit_in = 1'b0; req_valid = '0; req_tail = '0;
        #1; chk_state("c_done", 5'b0, 5'b0, 1'b0, 3'd2);

        // Credit stall: L streams non-tail flits with no returns.
        rst = 1'b1; cyc(); rst = 1'b0;
        req_valid = 5'b00001;
        #1; cyc();
        for (int i = 0; i < 6; i++) begin
            chk_state($sformatf("d_flit%0d", i), (i < 4) ? 5'b00001 : 5'b0, 5'b00001,
                      1'b1, (i < 4) ? 3'(4 - i) : 3'd0);
            cyc();
        end
        credit_in = 1'b1;
        #1; chk_state("d_ret", 5'b0, 5'b00001, 1'b1, 3'd0);
        cyc(); credit_in = 1'b0;
        #1; chk_state("d_one", 5'b00001, 5'b00001, 1'b1, 3'd1);
        cyc(); chk_state("d_stall", 5'b0, 5'b00001, 1'b1, 3'd0);

        // Reset while W owns the output mid-packet.
        rst = 1'b1; cyc(); rst = 1'b0;
        req_valid = 5'b01000;
        #1; cyc(); chk_state("e_lock", 5'b01000, 5'b01000, 1'b1, 3'd4);
        rst = 1'b1;
        cyc(); chk_state("e_rst", 5'b0, 5'b0, 1'b0, 3'd4);
        chk("e_rst.err", 32'(credit_err), 32'd0);
        rst = 1'b0; req_valid = 5'b11111; req_tail = 5'b11111;
        cyc(); chk_state("e_rr", 5'b00001, 5'b00001, 1'b1, 3'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/noc_output_allocator.md
Name: noc_output_allocator

Overview:
Per-output-port allocator for the 5-port NoC router (L, N, E, W, S).
- Shares one output link between the five input ports using round-robin arbitration with packet-level locking: the winner keeps the output until its tail flit is sent.
- Drives the crossbar select and the flit handshake toward the downstream router.
- Uses credit-based flow control: the downstream input buffer depth is tracked locally, replacing the per-flit RTS/DCTS handshake.
- One instance per router output.

Parameters:
- DEPTH, 4: downstream input-buffer depth in flits; reset value of the credit count; legal range 1..15.
- CW, $clog2(DEPTH+1): credit counter width (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  5  per-input flit pending for this output; index 0=L, 1=N, 2=E, 3=W, 4=S
- req_tail  in  5  per-input: the pending flit is a packet tail; qualified by req_valid
- credit_in  in  1  one-cycle pulse: downstream freed one buffer slot
- grant  out  5  one-hot: the owner's flit is consumed this cycle
- xbar_sel  out  5  one-hot crossbar select of the owner; 0 when idle
- flit_send  out  1  flit valid toward downstream; equals |grant
- credit_cnt  out  CW  current credits
- busy  out  1  output is locked to an owner
- credit_err  out  1  sticky flag: credit returned while the counter was full

Behaviour:
- Reset (rst sampled high at a posedge):
  - state=IDLE, owner=0, rr_ptr=0 (L highest priority).
  - credit_cnt=DEPTH, credit_err=0.
  - Outputs grant=0, xbar_sel=0, flit_send=0, busy=0.
  - Reset mid-packet abandons the lock with no tail required.
- States are IDLE and LOCKED, both registered.
- IDLE:
  - grant=0, xbar_sel=0, busy=0.
  - If any req_valid is set, the winner is the first set bit searching upward from rr_ptr, wrapping 4→0.
  - Next cycle: owner=winner, state=LOCKED.
  - Arbitration ignores credits; it never grants.
- LOCKED:
  - busy=1, xbar_sel=onehot(owner).
  - grant=onehot(owner) when req_valid[owner] && credit_cnt!=0, else 0. Combinational from registers and inputs, no added latency.
  - Requests from non-owners are ignored while LOCKED.
  - On a cycle with grant && req_tail[owner]: next state=IDLE, rr_ptr=(owner+1) mod 5.
  - A single-flit packet (head=tail) therefore occupies exactly 2 cycles: arbitration, then send.
  - If req_valid[owner] drops mid-packet, stay LOCKED and wait; there is no timeout.
- Credits:
  - Next credit_cnt = credit_cnt − flit_send + credit_in.
  - Simultaneous send and return: net unchanged.
  - credit_in while credit_cnt==DEPTH and no send: count holds at DEPTH and credit_err is set (sticky until rst).
  - Underflow is impossible because grant requires credit_cnt!=0.
- Back-to-back packets: after a tail at cycle t, IDLE at t+1 (arbitration), the new owner is LOCKED at t+2. No grant occurs in the IDLE cycle.

Decomposition:
- Package noc_pkg:
  - NUM_PORTS=5.
  - Port index constants P_L=0, P_N=1, P_E=2, P_W=3, P_S=4.
  - alloc_state_t enum {IDLE, LOCKED}.
  - Function onehot5(idx).
- Sub-module rr_arbiter5: combinational round-robin picker; inputs req[4:0] and ptr[2:0]; outputs winner[2:0] and any. rr_ptr storage stays in the top level.
- Top level holds the FSM, owner, rr_ptr, credit counter and error flag.

Test Plan:
- Single-flit packet: rst then release; req_valid=5'b00100, req_tail=5'b00100 → cycle 1 IDLE; cycle 2 grant=5'b00100, xbar_sel=5'b00100, flit_send=1, credit_cnt 4→3; cycle 3 busy=0, rr_ptr=3.
- Round-robin fairness: all five requesting single-flit packets continuously from reset → grant order L, N, E, W, S, L (0,1,2,3,4,0), one grant every 2 cycles.
- Packet lock: E sends a 3-flit packet (tail on 3rd) while N requests throughout → three consecutive grants to E (5'b00100); N is granted only after E's tail plus one IDLE cycle.
- Credit stall: DEPTH=4, no credit_in, owner L streaming 6 non-tail flits → 4 grants, credit_cnt=0, grant=0 while busy=1; one credit_in pulse → exactly one further grant.
- Simultaneous send and return, and overflow: send with credit_in in the same cycle at credit_cnt=2 → stays 2. credit_in at credit_cnt=4 with no send → count stays 4, credit_err=1 and remains 1 until rst.
- Reset mid-packet: rst asserted during LOCKED owner=3 → next cycle busy=0, xbar_sel=0, credit_cnt=DEPTH, credit_err=0, rr_ptr=0.
